usb_pkt_decoder: RTL
====================

Name: usb_pkt_decoder

Overview:
- Parametrised receive-side USB packet decoder, the successor to the combined rx/tx packet block. Sits between the ULPI/UTMI byte-stream receiver and the transaction/endpoint layer.
- Parses PID, token, SOF, handshake and data packets and checks CRC5/CRC16. Filters on device address and a per-endpoint enable mask, enforces MAX_PACKET_SIZE, and streams payload with the CRC stripped.
- Adds over the previous generation: explicit error reporting, payload length, endpoint count, babble detection, SOF frame number.

Parameters:
MAX_PACKET_SIZE, 512, largest accepted payload in bytes (8..1024)
ENDPOINTS, 4, number of endpoints decoded (1..16); endpoint numbers >= ENDPOINTS are ignored
LEN_W, $clog2(MAX_PACKET_SIZE+1), width of payload length output (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
axis_rx_tvalid_i  in  1  received byte valid
axis_rx_tready_o  out  1  constant 1, receiver cannot be stalled
axis_rx_tlast_i  in  1  last byte of packet
axis_rx_tdata_i  in  8  received byte, PID first
device_address  in  7  current device address
ep_enable  in  ENDPOINTS  per-endpoint accept mask
tok_valid  out  1  strobe: valid token for this device
tok_type  out  2  token PID[3:2] (00 OUT, 10 IN, 11 SETUP, 01 reserved)
tok_addr  out  7  token address
tok_endp  out  4  token endpoint
sof_valid  out  1  strobe: valid SOF
sof_frame  out  11  frame number
hsk_valid  out  1  strobe: handshake received after a matching token
hsk_type  out  2  handshake PID[3:2]
dat_tvalid  out  1  payload byte valid
dat_tlast  out  1  final payload byte
dat_tdata  out  8  payload byte
dat_type  out  2  data PID[3:2] (DATA0/1/2/MDATA)
dat_end  out  1  strobe: data packet complete
dat_crc_ok  out  1  CRC16 matched, qualified by dat_end
dat_len  out  LEN_W  payload byte count, qualified by dat_end
err_pid  out  1  strobe: PID check-nibble mismatch or reserved PID
err_crc5  out  1  strobe: token/SOF CRC5 mismatch
err_len  out  1  strobe: token/SOF not exactly 3 bytes, handshake not 1 byte, or data < 3 bytes
err_babble  out  1  strobe: payload exceeded MAX_PACKET_SIZE

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; token-match flag cleared. Reset mid-packet abandons the packet. Stray bytes arriving afterwards fall under the PID rule below.
- Beats with tvalid=0 are ignored everywhere; counters and CRC advance only on valid beats.
- States:
  - IDLE: first valid beat is the PID. PID[3:0] != ~PID[7:4] or reserved PID -> err_pid, go to DROP, or stay in IDLE if tlast.
    - SOF (0101) -> SOF.
    - PID[1:0]=01 -> TOKEN.
    - PID[1:0]=11 -> DATA.
    - PID[1:0]=10 handshake: must carry tlast. Then hsk_valid=match flag, hsk_type latched. Without tlast -> err_len and DROP.
    - PING/SPLIT/PRE are treated as reserved.
  - TOKEN/SOF: capture bytes 1,2 as {crc5, data11}; on tlast go to CHECK.
  - CHECK (1 cycle):
    - byte count != 3 -> err_len.
    - CRC5 mismatch -> err_crc5.
    - Otherwise SOF -> sof_valid, sof_frame=data11. Token -> tok_* driven.
    - Match flag := (addr==device_address && endp<ENDPOINTS && ep_enable[endp]). tok_valid=match flag.
    - Return to IDLE.
  - DATA: 2-byte delay line holds the last two bytes (the CRC candidates). Each byte pushed out of the delay line is emitted on dat_tdata the cycle after the beat that displaced it, and is CRC16-accumulated (init FFFF, residual compare to the inverted bit-reversed register). dat_tvalid is gated by the match flag.
    - On the tlast beat: next cycle drives dat_end=match flag, dat_tlast with the final payload byte (if any), dat_len, and dat_crc_ok. Then IDLE.
    - Zero-length packet: dat_end with dat_tvalid=0 and dat_len=0.
    - Payload count > MAX_PACKET_SIZE: further bytes are not emitted, dat_len saturates, err_babble pulses once, dat_crc_ok=0.
    - Fewer than 2 bytes after the PID -> err_len, no dat_end.
  - DROP: discard until a tlast beat, then IDLE.
- Match flag is cleared by any data packet end, handshake or SOF. It is consumed once per transaction.
- All strobes are single-cycle, registered. Latency tlast-beat -> strobe is 1 cycle.
- A tlast on a PID beat with tvalid while in IDLE is handled in the same cycle (no DROP).

Test Plan:
- OUT token A5-style bytes {E1, 0x02|ep1<<7, crc} with addr=2, ep_enable=4'b0010 -> tok_valid=1, tok_type=00, tok_endp=1, one cycle after tlast; repeat with ep_enable=0 -> tok_valid=0, no error.
- SOF {A5, 0x00, 0x10} for frame 0 (exact spec CRC) -> sof_valid=1, sof_frame=0; corrupt CRC bit -> err_crc5=1, sof_valid=0.
- After matching token: DATA0 {C3, 01 02 03 04, good CRC16} with gaps in tvalid -> dat_tdata 01..04, dat_tlast on 04, dat_end=1, dat_len=4, dat_crc_ok=1, dat_type=00; flip one payload bit -> dat_crc_ok=0.
- ZLP DATA1 {4B, 00, 00} -> dat_end=1, dat_len=0, dat_crc_ok=1, dat_tvalid never asserted.
- MAX_PACKET_SIZE=8, send 10-byte payload -> 8 bytes emitted, err_babble single pulse, dat_len=8, dat_crc_ok=0.
- PID 0xC2 (bad check nibble) followed by 3 bytes, tlast -> err_pid=1, no other strobes; assert rst_n=0 mid-DATA -> all outputs 0 immediately, next valid packet decoded normally.

Source files
------------

// File: rtl/usb_pkt_decoder.sv
// Receive-side USB packet decoder: PID/token/SOF/handshake/data parsing with
// CRC5/CRC16 checking, address/endpoint filtering and CRC-stripped payload stream.
module usb_pkt_decoder #(
  parameter int MAX_PACKET_SIZE = 512,
  parameter int ENDPOINTS       = 4,
  parameter int LEN_W           = $clog2(MAX_PACKET_SIZE+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 axis_rx_tvalid_i,
  output logic                 axis_rx_tready_o,
  input  logic                 axis_rx_tlast_i,
  input  logic [7:0]           axis_rx_tdata_i,
  input  logic [6:0]           device_address,
  input  logic [ENDPOINTS-1:0] ep_enable,
  output logic                 tok_valid,
  output logic [1:0]           tok_type,
  output logic [6:0]           tok_addr,
  output logic [3:0]           tok_endp,
  output logic                 sof_valid,
  output logic [10:0]          sof_frame,
  output logic                 hsk_valid,
  output logic [1:0]           hsk_type,
  output logic                 dat_tvalid,
  output logic                 dat_tlast,
  output logic [7:0]           dat_tdata,
  output logic [1:0]           dat_type,
  output logic                 dat_end,
  output logic                 dat_crc_ok,
  output logic [LEN_W-1:0]     dat_len,
  output logic                 err_pid,
  output logic                 err_crc5,
  output logic                 err_len,
  output logic                 err_babble
);
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TOKEN = 3'd1;
  localparam logic [2:0] ST_SOF   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_DROP  = 3'd4;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PACKET_SIZE);
  localparam logic [4:0]       EP_N    = 5'(ENDPOINTS);

  // CRC5 field as it appears on the wire in byte 2 bits [7:3]
  function automatic logic [4:0] crc5_field(input logic [10:0] d);
    logic [4:0] c;
    c = 5'h1f;
    for (int i = 0; i < 11; i++)
      c = (c[4] ^ d[i]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
    c = ~c;
    return {c[0], c[1], c[2], c[3], c[4]};
  endfunction

  // Reflected CRC16 (poly 0x8005), LSB-first byte update
  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ({1'b0, c[15:1]} ^ 16'hA001) : {1'b0, c[15:1]};
    return c;
  endfunction

  logic [2:0]       state;
  logic [3:0]       pid;
  logic [1:0]       cnt;
  logic [7:0]       tk_b1;
  logic             match;
  logic [7:0]       dl0, dl1;
  logic [15:0]      crc;
  logic [LEN_W-1:0] pcnt;
  logic             babble;

  logic [7:0]       b;
  logic             last;
  logic             pid_ok, push, over, babble_nx, tok_match;
  logic [10:0]      tk_d11;
  logic [15:0]      crc_nx, ep_pad;
  logic [LEN_W-1:0] pcnt_nx;

  assign axis_rx_tready_o = 1'b1;
  assign b    = axis_rx_tdata_i;
  assign last = axis_rx_tlast_i;

  always_comb begin
    ep_pad = '0;
    ep_pad[ENDPOINTS-1:0] = ep_enable;
    pid_ok    = (b[3:0] == ~b[7:4]) && (b[1:0] != 2'b00);
    tk_d11    = {b[2:0], tk_b1};
    tok_match = (tk_b1[6:0] == device_address) && ({1'b0, tk_d11[10:7]} < EP_N)
                && ep_pad[tk_d11[10:7]];
    // cnt==2 means the delay line is full, so this beat pushes a payload byte out
    push      = (cnt == 2'd2);
    over      = (pcnt == MAX_LEN);
    pcnt_nx   = (push && !over) ? pcnt + LEN_W'(1) : pcnt;
    babble_nx = babble | (push && over);
    crc_nx    = push ? crc16_byte(crc, dl0) : crc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;  pid <= '0;  cnt <= '0;  tk_b1 <= '0;  match <= 1'b0;
      dl0 <= '0;  dl1 <= '0;  crc <= 16'hFFFF;  pcnt <= '0;  babble <= 1'b0;
      tok_valid <= 1'b0;  tok_type <= '0;  tok_addr <= '0;  tok_endp <= '0;
      sof_valid <= 1'b0;  sof_frame <= '0;  hsk_valid <= 1'b0;  hsk_type <= '0;
      dat_tvalid <= 1'b0;  dat_tlast <= 1'b0;  dat_tdata <= '0;  dat_type <= '0;
      dat_end <= 1'b0;  dat_crc_ok <= 1'b0;  dat_len <= '0;
      err_pid <= 1'b0;  err_crc5 <= 1'b0;  err_len <= 1'b0;  err_babble <= 1'b0;
    end else begin
      tok_valid <= 1'b0;  sof_valid <= 1'b0;  hsk_valid <= 1'b0;
      dat_tvalid <= 1'b0;  dat_tlast <= 1'b0;  dat_end <= 1'b0;
      err_pid <= 1'b0;  err_crc5 <= 1'b0;  err_len <= 1'b0;  err_babble <= 1'b0;
      if (axis_rx_tvalid_i) begin
        case (state)
          ST_IDLE: begin
            pid <= b[3:0];  cnt <= '0;  pcnt <= '0;  babble <= 1'b0;  crc <= 16'hFFFF;
            if (!pid_ok) begin
              err_pid <= 1'b1;
              if (!last) state <= ST_DROP;
            end else if (b[1:0] == 2'b10) begin
              if (last) begin
                hsk_valid <= match;  hsk_type <= b[3:2];  match <= 1'b0;
              end else begin
                err_len <= 1'b1;  state <= ST_DROP;
              end
            end else if (last) begin
              err_len <= 1'b1;
            end else if (b[1:0] == 2'b11) begin
              state <= ST_DATA;  dat_type <= b[3:2];
            end else begin
              state <= (b[3:0] == 4'b0101) ? ST_SOF : ST_TOKEN;
            end
          end
          // The 3-byte check is evaluated on the tlast beat itself, so the
          // result strobes appear one cycle after that beat.
          ST_TOKEN, ST_SOF: begin
            if (cnt == 2'd0) tk_b1 <= b;
            if (cnt != 2'd3) cnt <= cnt + 2'd1;
            if (last) begin
              state <= ST_IDLE;
              if (cnt != 2'd1)                    err_len  <= 1'b1;
              else if (crc5_field(tk_d11) != b[7:3]) err_crc5 <= 1'b1;
              else if (state == ST_SOF) begin
                sof_valid <= 1'b1;  sof_frame <= tk_d11;  match <= 1'b0;
              end else begin
                tok_valid <= tok_match;  tok_type <= pid[3:2];
                tok_addr  <= tk_b1[6:0];  tok_endp <= tk_d11[10:7];
                match     <= tok_match;
              end
            end
          end
          ST_DATA: begin
            dl0 <= dl1;  dl1 <= b;
            if (cnt != 2'd2) cnt <= cnt + 2'd1;
            if (push) begin
              crc <= crc_nx;
              if (!over) begin
                dat_tvalid <= match;  dat_tdata <= dl0;  pcnt <= pcnt_nx;
              end else if (!babble) begin
                babble <= 1'b1;  err_babble <= 1'b1;
              end
            end
            if (last) begin
              state <= ST_IDLE;  match <= 1'b0;
              if (cnt == 2'd0) err_len <= 1'b1;
              else begin
                dat_end    <= match;
                dat_tlast  <= match && push && !over;
                dat_len    <= pcnt_nx;
                dat_crc_ok <= !babble_nx && (~crc_nx == {b, dl1});
              end
            end
          end
          ST_DROP: if (last) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
